// File: rtl/conv2d_accel_param.sv
// Multi-channel int8 2-D convolution engine: KxK kernels plus int16 bias per output channel,
// requantised by a runtime arithmetic shift with optional ReLU, one tap per clock.
module conv2d_accel_param #(
    parameter int unsigned IN_W   = 40,
    parameter int unsigned IN_H   = 49,
    parameter int unsigned K      = 3,
    parameter int unsigned STRIDE = 1,
    parameter int unsigned OUT_CH = 4,
    parameter int unsigned ACC_W  = 24,
    parameter int unsigned IN_AW  = 11,
    parameter int unsigned OUT_AW = 13,
    parameter int unsigned W_AW   = 8,
    parameter int unsigned B_AW   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [4:0]        shift,
    input  logic              relu_en,
    output logic              busy,
    output logic              done,
    output logic [IN_AW-1:0]  ram_addr,
    input  logic [7:0]        ram_rdata,
    output logic [W_AW-1:0]   w_addr,
    input  logic [7:0]        w_rdata,
    output logic [B_AW-1:0]   b_addr,
    input  logic [15:0]       b_rdata,
    output logic [OUT_AW-1:0] out_ram_addr,
    output logic              out_ram_wen,
    output logic [7:0]        out_ram_wdata
);
    localparam int unsigned OUT_W = (IN_W - K) / STRIDE + 1;
    localparam int unsigned OUT_H = (IN_H - K) / STRIDE + 1;
    localparam int unsigned KK    = K * K;
    localparam int unsigned OCW   = (OUT_CH > 1) ? $clog2(OUT_CH) : 1;
    localparam int unsigned YW    = (OUT_H > 1) ? $clog2(OUT_H) : 1;
    localparam int unsigned XW    = (OUT_W > 1) ? $clog2(OUT_W) : 1;
    localparam int unsigned KW    = (K > 1) ? $clog2(K) : 1;
    localparam int unsigned TW    = (KK > 1) ? $clog2(KK) : 1;
    localparam int unsigned EW    = ACC_W + 1;

    typedef enum logic [2:0] {StIdle, StBias, StMac, StLast, StDone} state_e;
    state_e state_q, state_d;

    logic [OCW-1:0]          oc_q;
    logic [YW-1:0]           oy_q;
    logic [XW-1:0]           ox_q;
    logic [KW-1:0]           ky_q, kx_q;
    logic [TW-1:0]           t_q;
    logic [OUT_AW-1:0]       pix_q;
    logic [4:0]              shift_q;
    logic                    relu_q;
    logic signed [ACC_W-1:0] acc_q;
    logic                    done_q, wen_q;
    logic [OUT_AW-1:0]       waddr_q;
    logic [7:0]              wdata_q;

    logic                    tap_last, pix_last;
    logic signed [15:0]      prod;
    logic signed [ACC_W-1:0] prod_ext, bias_ext, accf;
    logic signed [EW-1:0]    rnd, shifted;
    logic [7:0]              qval;

    assign tap_last = (t_q == TW'(KK - 1));
    assign pix_last = (oc_q == OCW'(OUT_CH - 1)) && (oy_q == YW'(OUT_H - 1)) &&
                      (ox_q == XW'(OUT_W - 1));

    assign busy          = (state_q != StIdle);
    assign done          = done_q;
    assign out_ram_wen   = wen_q;
    assign out_ram_addr  = waddr_q;
    assign out_ram_wdata = wdata_q;
    assign b_addr        = B_AW'(oc_q);
    assign w_addr        = W_AW'(oc_q) * W_AW'(KK) + W_AW'(t_q);
    assign ram_addr      = (IN_AW'(oy_q) * IN_AW'(STRIDE) + IN_AW'(ky_q)) * IN_AW'(IN_W) +
                           IN_AW'(ox_q) * IN_AW'(STRIDE) + IN_AW'(kx_q);

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (start) state_d = StBias;
            StBias:  state_d = StMac;
            StMac:   if (tap_last) state_d = StLast;
            StLast:  state_d = pix_last ? StDone : StBias;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Final tap is folded in combinationally during LAST, then rounded, clamped, saturated.
    always_comb begin
        prod     = $signed(ram_rdata) * $signed(w_rdata);
        prod_ext = {{(ACC_W - 16){prod[15]}}, prod};
        bias_ext = {{(ACC_W - 16){b_rdata[15]}}, b_rdata};
        accf     = acc_q + prod_ext;
        rnd      = {accf[ACC_W-1], accf};
        if (shift_q != 5'd0) rnd = rnd + (EW'(1) << (shift_q - 5'd1));
        shifted  = rnd >>> shift_q;
        if (relu_q && shifted[EW-1]) shifted = '0;
        if (!shifted[EW-1] && (|shifted[EW-2:7]))      qval = 8'h7f;
        else if (shifted[EW-1] && !(&shifted[EW-2:7])) qval = 8'h80;
        else                                           qval = shifted[7:0];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            oc_q    <= '0;
            oy_q    <= '0;
            ox_q    <= '0;
            ky_q    <= '0;
            kx_q    <= '0;
            t_q     <= '0;
            pix_q   <= '0;
            shift_q <= '0;
            relu_q  <= 1'b0;
            acc_q   <= '0;
            done_q  <= 1'b0;
            wen_q   <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            wen_q   <= 1'b0;
            done_q  <= (state_q == StDone);
            case (state_q)
                StIdle: begin
                    if (start) begin
                        shift_q <= (32'(shift) > ACC_W - 1) ? 5'(ACC_W - 1) : shift;
                        relu_q  <= relu_en;
                        oc_q    <= '0;
                        oy_q    <= '0;
                        ox_q    <= '0;
                        ky_q    <= '0;
                        kx_q    <= '0;
                        t_q     <= '0;
                        pix_q   <= '0;
                    end
                end
                StMac: begin
                    acc_q <= (t_q == '0) ? bias_ext : accf;
                    if (tap_last) begin
                        t_q  <= '0;
                        ky_q <= '0;
                        kx_q <= '0;
                    end else begin
                        t_q <= t_q + TW'(1);
                        if (kx_q == KW'(K - 1)) begin
                            kx_q <= '0;
                            ky_q <= ky_q + KW'(1);
                        end else begin
                            kx_q <= kx_q + KW'(1);
                        end
                    end
                end
                StLast: begin
                    wen_q   <= 1'b1;
                    waddr_q <= pix_q;
                    wdata_q <= qval;
                    // Counters hold on the final pixel so nothing ever wraps.
                    if (!pix_last) begin
                        pix_q <= pix_q + OUT_AW'(1);
                        if (ox_q == XW'(OUT_W - 1)) begin
                            ox_q <= '0;
                            if (oy_q == YW'(OUT_H - 1)) begin
                                oy_q <= '0;
                                oc_q <= oc_q + OCW'(1);
                            end else begin
                                oy_q <= oy_q + YW'(1);
                            end
                        end else begin
                            ox_q <= ox_q + XW'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_conv2d_accel_param.sv
// Bench for conv2d_accel_param: 7x7 map, 3x3 kernels, stride 2, two channels, registered mocks,
// checked every cycle against an arithmetic model of the convolution and its timing.
module tb_conv2d_accel_param;
    localparam int IN_W = 7, IN_H = 7, K = 3, STRIDE = 2, OUT_CH = 2, ACC_W = 24;
    localparam int IN_AW = 6, OUT_AW = 5, W_AW = 5, B_AW = 1;
    localparam int OUT_W = (IN_W - K) / STRIDE + 1;
    localparam int OUT_H = (IN_H - K) / STRIDE + 1;
    localparam int NPIX  = OUT_CH * OUT_H * OUT_W;
    localparam int P     = K * K + 2;

    logic              clk = 1'b0, rst_n = 1'b0, start = 1'b0, relu_en = 1'b0;
    logic [4:0]        shift = 5'd0;
    logic              busy, done, out_ram_wen;
    logic [IN_AW-1:0]  ram_addr;
    logic [W_AW-1:0]   w_addr;
    logic [B_AW-1:0]   b_addr;
    logic [OUT_AW-1:0] out_ram_addr;
    logic [7:0]        out_ram_wdata;
    logic [7:0]        ram_rdata = 8'd0, w_rdata = 8'd0;
    logic [15:0]       b_rdata = 16'd0;

    logic [7:0]  in_mem[64];
    logic [7:0]  w_mem[32];
    logic [15:0] b_mem[2];

    int checks = 0, passed = 0, cyc = 0;
    int e0 = 0, wr_idx = 0, done_cnt = 0;
    bit running = 1'b0, chk_en = 1'b0;
    int exp_q[NPIX];
    int rel_c, n_c, ph_c, oc_c, oy_c, ox_c, t_c;

    conv2d_accel_param #(
        .IN_W(IN_W), .IN_H(IN_H), .K(K), .STRIDE(STRIDE), .OUT_CH(OUT_CH), .ACC_W(ACC_W),
        .IN_AW(IN_AW), .OUT_AW(OUT_AW), .W_AW(W_AW), .B_AW(B_AW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .shift(shift), .relu_en(relu_en),
        .busy(busy), .done(done), .ram_addr(ram_addr), .ram_rdata(ram_rdata),
        .w_addr(w_addr), .w_rdata(w_rdata), .b_addr(b_addr), .b_rdata(b_rdata),
        .out_ram_addr(out_ram_addr), .out_ram_wen(out_ram_wen), .out_ram_wdata(out_ram_wdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc       <= cyc + 1;
        ram_rdata <= in_mem[ram_addr];
        w_rdata   <= w_mem[w_addr];
        b_rdata   <= b_mem[b_addr];
    end

    function automatic void check(input string name, input longint act, input longint expv);
        checks++;
        if (act == expv) passed++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, expv, cyc);
    endfunction

    function automatic int in_addr(input int oy, input int ox, input int ky, input int kx);
        return (oy * STRIDE + ky) * IN_W + ox * STRIDE + kx;
    endfunction

    // Plain-arithmetic reference: dot product, round-half-up division, ReLU, int8 saturation.
    function automatic void build_model(input int sh, input bit rl);
        for (int n = 0; n < NPIX; n++) begin
            int oc, oy, ox, s;
            longint acc, num, d, r;
            oc  = n / (OUT_H * OUT_W);
            oy  = (n % (OUT_H * OUT_W)) / OUT_W;
            ox  = n % OUT_W;
            acc = longint'($signed(b_mem[oc]));
            for (int ky = 0; ky < K; ky++)
                for (int kx = 0; kx < K; kx++)
                    acc += longint'($signed(in_mem[in_addr(oy, ox, ky, kx)])) *
                           longint'($signed(w_mem[oc * K * K + ky * K + kx]));
            s = (sh > ACC_W - 1) ? ACC_W - 1 : sh;
            if (s > 0) begin
                d   = longint'(1) << s;
                num = acc + d / 2;
                r   = num / d;
                if ((num % d != 0) && (num < 0)) r = r - 1;
            end else begin
                r = acc;
            end
            if (rl && r < 0) r = 0;
            if (r > 127) r = 127;
            if (r < -128) r = -128;
            exp_q[n] = int'(r);
        end
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            if (running) begin
                rel_c = cyc - e0;
                check("busy", longint'(busy), longint'(rel_c <= NPIX * P));
                n_c  = rel_c / P;
                ph_c = rel_c % P;
                if (n_c < NPIX && ph_c <= K * K) begin
                    oc_c = n_c / (OUT_H * OUT_W);
                    oy_c = (n_c % (OUT_H * OUT_W)) / OUT_W;
                    ox_c = n_c % OUT_W;
                    if (ph_c == 0) begin
                        check("b_addr", longint'(b_addr), oc_c);
                    end else begin
                        t_c = ph_c - 1;
                        check("ram_addr", longint'(ram_addr), in_addr(oy_c, ox_c, t_c / K, t_c % K));
                        check("w_addr", longint'(w_addr), oc_c * K * K + t_c);
                    end
                end
            end else begin
                check("busy_idle", longint'(busy), 0);
            end
            if (out_ram_wen) begin
                check("wen_expected", longint'(running && wr_idx < NPIX), 1);
                if (running && wr_idx < NPIX) begin
                    check("wr_addr", longint'(out_ram_addr), wr_idx);
                    check("wr_data", longint'($signed(out_ram_wdata)), exp_q[wr_idx]);
                    check("wr_time", cyc, e0 + (wr_idx + 1) * P);
                    wr_idx++;
                end
            end
            if (done) begin
                check("done_expected", longint'(running), 1);
                if (running) begin
                    check("done_time", cyc, e0 + NPIX * P + 1);
                    check("writes_at_done", wr_idx, NPIX);
                    done_cnt++;
                end
            end
        end
    end

    task automatic launch(input int sh, input bit rl);
        shift   = 5'(sh);
        relu_en = rl;
        start   = 1'b1;
        @(posedge clk);
        #1;
        e0       = cyc;
        wr_idx   = 0;
        done_cnt = 0;
        running  = 1'b1;
        start    = 1'b0;
        // Run must use the latched values, not these.
        shift    = 5'($urandom);
        relu_en  = 1'($urandom);
    endtask

    task automatic wait_done();
        bit got = 1'b0;
        for (int i = 0; i < NPIX * P + 20 && !got; i++) begin
            @(negedge clk);
            got = done;
        end
        check("done_seen", longint'(got), 1);
    endtask

    task automatic close_run();
        @(posedge clk);
        #1;
        running = 1'b0;
        check("write_count", wr_idx, NPIX);
        check("done_count", done_cnt, 1);
        check("busy_after", longint'(busy), 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, longint'(busy), 0);
        check({tag, "_done"}, longint'(done), 0);
        check({tag, "_wen"}, longint'(out_ram_wen), 0);
        check({tag, "_waddr"}, longint'(out_ram_addr), 0);
        check({tag, "_wdata"}, longint'(out_ram_wdata), 0);
        check({tag, "_ram_addr"}, longint'(ram_addr), 0);
        check({tag, "_w_addr"}, longint'(w_addr), 0);
        check({tag, "_b_addr"}, longint'(b_addr), 0);
    endtask

    task automatic randomize_mems();
        for (int i = 0; i < 64; i++) in_mem[i] = 8'($urandom);
        for (int i = 0; i < 32; i++) w_mem[i] = 8'($urandom);
        for (int i = 0; i < 2; i++) b_mem[i] = 16'($urandom);
    endtask

    initial begin
        int sh, cnt;
        bit rl;
        for (int i = 0; i < 64; i++) in_mem[i] = 8'(i);
        for (int i = 0; i < 32; i++) w_mem[i] = 8'd1;
        b_mem[0] = 16'd0;
        b_mem[1] = 16'd0;

        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst_n  = 1'b1;
        chk_en = 1'b1;

        // Ramp input, unit weights, shift 2.
        build_model(2, 1'b0);
        check("model_pix0", exp_q[0], 18);
        check("model_pix1", exp_q[1], 23);
        check("model_addr_011", in_addr(1, 1, 0, 0), 16);
        launch(2, 1'b0);
        wait_done();
        close_run();

        // Saturation and ReLU.
        for (int i = 0; i < 64; i++) in_mem[i] = 8'd127;
        for (int i = 0; i < 32; i++) w_mem[i] = 8'd127;
        build_model(0, 1'b0);
        check("model_sat_pos", exp_q[5], 127);
        launch(0, 1'b0);
        wait_done();
        close_run();
        for (int i = 0; i < 32; i++) w_mem[i] = 8'h80;
        build_model(0, 1'b0);
        check("model_sat_neg", exp_q[0], -128);
        launch(0, 1'b0);
        wait_done();
        close_run();
        build_model(0, 1'b1);
        check("model_relu", exp_q[0], 0);
        launch(0, 1'b1);
        wait_done();
        close_run();

        // Rounding: single tap product 6, negative bias, large bias.
        for (int i = 0; i < 64; i++) in_mem[i] = 8'd0;
        for (int i = 0; i < 32; i++) w_mem[i] = 8'd0;
        in_mem[0] = 8'd2;
        w_mem[0]  = 8'd3;
        b_mem[1]  = 16'hfffa;
        build_model(2, 1'b0);
        check("model_round_pos", exp_q[0], 2);
        check("model_round_neg", exp_q[9], -1);
        launch(2, 1'b0);
        wait_done();
        close_run();
        b_mem[1] = 16'd300;
        build_model(1, 1'b0);
        check("model_bias_sat", exp_q[9], 127);
        launch(1, 1'b0);
        wait_done();
        close_run();

        // Random data; a start pulse while busy must be ignored.
        randomize_mems();
        sh = $urandom_range(0, 12);
        rl = 1'($urandom);
        build_model(sh, rl);
        launch(sh, rl);
        repeat (30) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done();
        close_run();

        // Back-to-back: second start in the cycle after done.
        randomize_mems();
        sh = $urandom_range(0, 31);
        rl = 1'($urandom);
        build_model(sh, rl);
        launch(sh, rl);
        wait_done();
        launch(sh, rl);
        check("b2b_busy", longint'(busy), 1);
        wait_done();
        close_run();

        for (int r = 0; r < 3; r++) begin
            randomize_mems();
            sh = $urandom_range(0, 12);
            rl = 1'($urandom);
            build_model(sh, rl);
            launch(sh, rl);
            wait_done();
            close_run();
        end

        // Reset for one cycle during the MAC phase of pixel 5.
        randomize_mems();
        sh = $urandom_range(0, 10);
        rl = 1'($urandom);
        build_model(sh, rl);
        launch(sh, rl);
        repeat (5 * P + 3) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n   = 1'b1;
        running = 1'b0;
        check_all_zero("midrun_reset");
        cnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (out_ram_wen || done) cnt++;
        end
        check("activity_after_reset", cnt, 0);
        launch(sh, rl);
        wait_done();
        close_run();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/conv2d_accel_param.md
# conv2d_accel_param

Parametrised 2-D convolution engine for the micro-speech feature path: it reads an int8 feature map (default 49x40 spectrogram) from the input RAM and convolves it with OUT_CH KxK int8 kernels plus per-channel int16 bias. The result is requantised by a runtime arithmetic shift with optional ReLU, then written as int8 to the output RAM. This is the multi-channel, stride- and kernel-configurable successor to the single-mode conv accelerator. It keeps the same start/busy/done handshake and one-cycle-latency RAM ports.

## Interface
- IN_W, 40, input map width (columns)
- IN_H, 49, input map height (rows)
- K, 3, square kernel size (1..5)
- STRIDE, 1, convolution stride (1 or 2)
- OUT_CH, 4, number of output channels / kernels
- ACC_W, 24, accumulator width; must be ≥ 16+clog2(K*K)+2
- IN_AW, 11; OUT_AW, 13; W_AW, 8; B_AW, 4: address widths
- Derived: OUT_W=(IN_W-K)/STRIDE+1, OUT_H=(IN_H-K)/STRIDE+1, NPIX=OUT_CH*OUT_H*OUT_W (default 7144)
- clk  in  1  single clock, all logic on rising edge
- rst_n  in  1  reset, synchronous, active-low
- start  in  1  begin a run; sampled only in IDLE
- shift  in  5  requant right-shift, latched at start
- relu_en  in  1  clamp negatives to 0, latched at start
- busy  out  1  high from start acceptance until done
- done  out  1  one-cycle pulse at run end
- ram_addr  out  IN_AW  input RAM read address
- ram_rdata  in  8  signed input data, valid one cycle after ram_addr
- w_addr  out  W_AW  weight ROM address, oc*K*K+ky*K+kx
- w_rdata  in  8  signed weight, one-cycle latency
- b_addr  out  B_AW  bias ROM address (= oc)
- b_rdata  in  16  signed bias, one-cycle latency
- out_ram_addr  out  OUT_AW  oc*OUT_H*OUT_W + oy*OUT_W + ox
- out_ram_wen  out  1  write strobe, one cycle per output pixel
- out_ram_wdata  out  8  signed result

## Operation
- FSM states: IDLE, BIAS, MAC, LAST, DONE.
- IDLE: when start=1, latch shift (values > ACC_W-1 clamp to ACC_W-1) and relu_en, clear oc/oy/ox, then go to BIAS. start in any other state is ignored.
- Loop order: oc outermost, then oy, then ox; taps ky outer, kx inner.
- BIAS (1 cycle): drive b_addr=oc.
- MAC (K*K cycles, tap t): drive ram_addr=(oy*STRIDE+ky)*IN_W+ox*STRIDE+kx and w_addr=oc*K*K+t.
  - Edge ending t=0: acc <= sign-extended b_rdata.
  - Edge ending t≥1: acc += ram_rdata*w_rdata for tap t-1 (signed 8x8 product).
- LAST (1 cycle): compute accf = acc + product of tap K*K-1. Then register the write:
  - r = (shift>0) ? (accf + (1<<(shift-1))) >>> shift : accf (arithmetic shift, round-half-up)
  - if relu_en and r<0, r=0
  - saturate r to [-128,127]
  - out_ram_wdata<=r, out_ram_addr<=pixel address, out_ram_wen<=1
- After LAST: advance ox/oy/oc and return to BIAS. After the final pixel, go to DONE.
- DONE: done=1 for one cycle, then IDLE.
- No accumulator overflow is possible given the ACC_W rule. Wrap-around of any counter is an error and never occurs.

## Timing
- Every output resets to 0 at the first rising edge with rst_n=0. While rst_n=0: FSM in IDLE, no writes, start ignored.
- Reset mid-run aborts the run immediately. No further out_ram_wen or done is issued. A pending write registered on the reset edge is dropped.
- Cycles per pixel: P=K*K+2 (BIAS + K*K MAC + LAST).
- Start accepted at edge E0: busy=1 from E0.
  - Pixel n's write strobe is high during cycle [E0+(n+1)P, E0+(n+1)P+1).
  - The write for pixel n overlaps BIAS of pixel n+1.
  - Final write at E0+NPIX*P. done high in cycle [E0+NPIX*P+1, +2). busy falls at E0+NPIX*P+1.
  - Default parameters: done at E0+78585.
- Input address and weight address change together each MAC cycle. Read data is consumed exactly one cycle later. No stalls, no back-pressure.
- Writes are in strictly increasing out_ram_addr order, 0..NPIX-1, each exactly once.
- A new start is accepted in the cycle after done (IDLE).

## Test plan
Mock RAM/ROM with one-cycle registered reads; small config IN_W=IN_H=5, K=3, STRIDE=1, OUT_CH=2 unless stated.
- ram_rdata=addr[7:0], all weights 1, bias 0, shift 0, relu off -> pixel (0,0,0) writes 54, pixel (0,0,1) writes 63. 18 writes total, addresses 0..17 in order, done pulse exactly one cycle after the last strobe, busy low after.
- Constant input 127, weights 127, bias 0 -> every output 127 (saturated). Weights -128 -> every output -128. Same weights with relu_en=1 -> every output 0.
- Rounding: one tap product 6 (others 0), bias 0, shift 2 -> 2. Bias -6, weights 0, shift 2 -> -1. Bias 300, shift 1 -> 127.
- STRIDE=2, IN_W=IN_H=7, OUT_CH=1 -> 9 writes. Pixel (0,1,1) reads base address 16. Total start-to-done = 9*11+1 cycles.
- Start pulsed again while busy -> ignored, write count unchanged. Start one cycle after done -> second identical run.
- rst_n=0 for one cycle mid-MAC of pixel 5 -> no further wen or done, all outputs 0. A fresh start afterwards completes normally from address 0.
